dmem_port_arbiter: RTL

Sequential arbiter sharing the single 64-bit data memory port between two requesters: requester 0 is the multicycle core datapath, and requester 1 is the program/debug loader. It sits between the requesters and `Memoria64_test`. It latches one request at a time, drives the memory address, data, write and size (`tam`) lines from internal registers, waits the memory read latency, and returns a `done` pulse with read data. Round-robin priority applies when both requesters ask in the same cycle.

---
 rtl/dmem_port_arbiter_pkg.sv | 25 ++
 rtl/dmem_port_arbiter_if.sv | 33 +++
 rtl/dmem_port_arbiter_rr_pick2.sv | 14 +
 rtl/dmem_port_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef logic [1:0] tam_t;

  localparam tam_t TAM_B = 2'b00;
  localparam tam_t TAM_H = 2'b01;
  localparam tam_t TAM_W = 2'b10;
  localparam tam_t TAM_D = 2'b11;

  localparam int REQ_CORE = 0;
  localparam int REQ_LOAD = 1;

  // Requester index to one-hot done/gnt vector.
  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared data-memory port.
interface dmem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    tam0;
  logic [1:0]    tam1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [1:0]    mem_tam;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, tam0, tam1, mem_rdata,
    output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_wr, mem_tam
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, tam0, tam1, mem_rdata,
    input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_wr, mem_tam
  );
endinterface

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last goes.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb begin
    win = 2'b00;
    if (req == 2'b11) win = last ? idx2oh(1'b0) : idx2oh(1'b1);
    else              win = req;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core (0) and the loader (1); one
// access in flight, outputs driven from registers latched at grant time.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(READ_LAT + 1);

  if (READ_LAT < 1) begin : g_lat_chk
    $error("dmem_port_arbiter: READ_LAT must be >= 1");
  end

  arb_state_t    r_state;
  logic          r_last;
  logic          r_owner;
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;
  logic [DW-1:0] r_rdata;
  logic          r_busy;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_wr;
  tam_t          r_mem_tam;

  logic [1:0]    w_win;
  logic          w_sel;

  rr_pick2 u_pick (
    .req  (bus.req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_sel = w_win[REQ_LOAD];

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_tam   = r_mem_tam;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_tam   <= TAM_B;
    end else begin
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_owner     <= w_sel;
            r_last      <= w_sel;
            r_we        <= bus.we[w_sel];
            r_mem_wr    <= bus.we[w_sel];
            r_mem_addr  <= w_sel ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
            r_mem_tam   <= w_sel ? bus.tam1   : bus.tam0;
            r_cnt       <= CW'(READ_LAT - 1);
            r_gnt       <= w_win;
            r_busy      <= 1'b1;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          // Writes take a single BUSY cycle; reads wait out the latency counter.
          if (r_we) begin
            r_mem_wr <= 1'b0;
            r_done   <= idx2oh(r_owner);
            r_state  <= DONE;
          end else if (r_cnt == '0) begin
            r_rdata  <= bus.mem_rdata;
            r_done   <= idx2oh(r_owner);
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
